// File: rtl/adc_frame_capture.sv
// Armed capture of one fixed-length ADC frame; sample pairs are sign-extended and packed into 32-bit FIFO words.
// Optional level trigger (trig_level_i, ARMED state) is enabled by defining ADC_FRAME_CAPTURE_TRIG_LEVEL_EN.
module adc_frame_capture #(
  parameter int SAMPLE_W  = 12,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm_i,
  input  logic                       sample_valid_i,
  input  logic [SAMPLE_W-1:0]        sample_data_i,
`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
  input  logic signed [SAMPLE_W-1:0] trig_level_i,
`endif
  input  logic                       fifo_full_i,
  input  logic                       clear_status_i,
  output logic                       fifo_wr_en_o,
  output logic [31:0]                fifo_din_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           sample_count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FINISH  = 2'd2,
    S_ARMED   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             state_q;
  logic               wr_en_q;
  logic [31:0]        din_q;
  logic               busy_q;
  logic               done_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   count_q;
  logic [15:0]        hold_q;

  logic signed [SAMPLE_W-1:0] s_data;
  logic signed [15:0]         sext;

  assign s_data = sample_data_i;
  assign sext   = 16'(s_data);

`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
  logic signed [SAMPLE_W-1:0] prev_q;
  logic                       prev_valid_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_en_q      <= 1'b0;
      din_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      count_q      <= '0;
      hold_q       <= '0;
`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      // A drop later in this block overrides the clear.
      if (clear_status_i) overflow_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            count_q <= '0;
            busy_q  <= 1'b1;
            hold_q  <= '0;
`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
            prev_valid_q <= 1'b0;
            state_q      <= S_ARMED;
`else
            state_q <= S_CAPTURE;
`endif
          end
        end

`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
        S_ARMED: begin
          if (sample_valid_i) begin
            // The crossing sample itself becomes index 0 of the frame.
            if (prev_valid_q && (prev_q < trig_level_i) && (trig_level_i <= s_data)) begin
              hold_q  <= sext;
              count_q <= CNT_W'(1);
              state_q <= S_CAPTURE;
            end else begin
              prev_q       <= s_data;
              prev_valid_q <= 1'b1;
            end
          end
        end
`endif

        S_CAPTURE: begin
          if (sample_valid_i) begin
            count_q <= count_q + CNT_W'(1);
            if (!count_q[0]) begin
              hold_q <= sext;
            end else if (fifo_full_i) begin
              overflow_q <= 1'b1;
            end else begin
              wr_en_q <= 1'b1;
              din_q   <= {sext, hold_q};
            end
            if (count_q == LAST_IDX) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end
          end
        end

        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_din_o     = din_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overflow_o     = overflow_q;
  assign sample_count_o = count_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture with an 8-sample frame and 12-bit samples.
module tb_adc_frame_capture;

  localparam int SAMPLE_W  = 12;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                arm = 1'b0;
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample_data = '0;
  logic                fifo_full = 1'b0;
  logic                clear_status = 1'b0;
  logic                fifo_wr_en;
  logic [31:0]         fifo_din;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [CNT_W-1:0]    sample_count;
`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
  logic [SAMPLE_W-1:0] trig_level = '0;
`endif

  int pass_n  = 0;
  int total_n = 0;

  logic [31:0] wr_log[$];
  int          done_n = 0;

  adc_frame_capture #(
    .SAMPLE_W (SAMPLE_W),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arm_i         (arm),
    .sample_valid_i(sample_valid),
    .sample_data_i (sample_data),
`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
    .trig_level_i  (trig_level),
`endif
    .fifo_full_i   (fifo_full),
    .clear_status_i(clear_status),
    .fifo_wr_en_o  (fifo_wr_en),
    .fifo_din_o    (fifo_din),
    .busy_o        (busy),
    .done_o        (done),
    .overflow_o    (overflow),
    .sample_count_o(sample_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr_en) wr_log.push_back(fifo_din);
    if (done) done_n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic send(input int v, input bit full);
    sample_data  = SAMPLE_W'(v);
    sample_valid = 1'b1;
    fifo_full    = full;
    step();
    sample_valid = 1'b0;
    fifo_full    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    total_n++;
    if ({fifo_wr_en, fifo_din, busy, done, overflow, sample_count} !== '0) begin
      $display("FAIL reset_outputs: wr=%b din=%h busy=%b done=%b ovf=%b cnt=%0d, required all 0",
               fifo_wr_en, fifo_din, busy, done, overflow, sample_count);
    end else pass_n++;
    rst_n = 1'b1;
    step();
    total_n++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      $display("FAIL idle_after_reset: busy=%b wr=%b, required 0/0", busy, fifo_wr_en);
    end else pass_n++;
  endtask

  task automatic test_basic_frame();
    int vals[8] = '{1, 2, -1, -2, 100, -100, 5, 6};
    logic [31:0] exp_w[4] = '{32'h0002_0001, 32'hFFFE_FFFF, 32'hFF9C_0064, 32'h0006_0005};
    int d0;
    wr_log.delete();
    d0 = done_n;
    pulse_arm();
    total_n++;
    if (busy !== 1'b1) $display("FAIL basic_busy_after_arm: got %b, required 1", busy);
    else pass_n++;
    for (int i = 0; i < 8; i++) send(vals[i], 1'b0);
    total_n++;
    if (done !== 1'b1 || fifo_wr_en !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL basic_done_with_last_write: done=%b wr=%b busy=%b, required 1/1/1", done, fifo_wr_en, busy);
    end else pass_n++;
    step();
    total_n++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_after_finish: done=%b busy=%b, required 0/0", done, busy);
    else pass_n++;
    total_n++;
    if (wr_log.size() !== 4) $display("FAIL basic_write_count: got %0d, required 4", wr_log.size());
    else pass_n++;
    for (int i = 0; i < 4; i++) begin
      total_n++;
      if (wr_log.size() <= i) $display("FAIL basic_word%0d: missing, required %h", i, exp_w[i]);
      else if (wr_log[i] !== exp_w[i]) $display("FAIL basic_word%0d: got %h, required %h", i, wr_log[i], exp_w[i]);
      else pass_n++;
    end
    total_n++;
    if (sample_count !== 4'd8 || overflow !== 1'b0 || done_n - d0 !== 1) begin
      $display("FAIL basic_status: cnt=%0d ovf=%b dones=%0d, required 8/0/1", sample_count, overflow, done_n - d0);
    end else pass_n++;
    step();
    total_n++;
    if (sample_count !== 4'd8) $display("FAIL count_holds_in_idle: got %0d, required 8", sample_count);
    else pass_n++;
  endtask

  task automatic test_sign_ext_arm_busy();
    pulse_arm();
    total_n++;
    if (sample_count !== 4'd0) $display("FAIL rearm_clears_count: got %0d, required 0", sample_count);
    else pass_n++;
    send(12'h800, 1'b0);
    send(12'h7FF, 1'b0);
    total_n++;
    if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h07FF_F800) begin
      $display("FAIL sign_ext_word: wr=%b din=%h, required 1/07fff800", fifo_wr_en, fifo_din);
    end else pass_n++;
    arm = 1'b1;
    send(0, 1'b0);
    arm = 1'b0;
    total_n++;
    if (sample_count !== 4'd3 || busy !== 1'b1) begin
      $display("FAIL arm_while_busy: cnt=%0d busy=%b, required 3/1", sample_count, busy);
    end else pass_n++;
    for (int i = 0; i < 5; i++) send(0, 1'b0);
    total_n++;
    if (done !== 1'b1 || sample_count !== 4'd8) $display("FAIL arm_busy_done: done=%b cnt=%0d, required 1/8", done, sample_count);
    else pass_n++;
    step();
  endtask

  task automatic test_overflow();
    int d0;
    wr_log.delete();
    d0 = done_n;
    pulse_arm();
    send(1, 1'b0);
    send(2, 1'b1);
    total_n++;
    if (fifo_wr_en !== 1'b0 || overflow !== 1'b1) $display("FAIL ovf_drop: wr=%b ovf=%b, required 0/1", fifo_wr_en, overflow);
    else pass_n++;
    for (int i = 3; i <= 8; i++) send(i, 1'b0);
    step();
    total_n++;
    if (wr_log.size() !== 3 || done_n - d0 !== 1 || overflow !== 1'b1) begin
      $display("FAIL ovf_frame: writes=%0d dones=%0d ovf=%b, required 3/1/1", wr_log.size(), done_n - d0, overflow);
    end else pass_n++;
    total_n++;
    if (wr_log.size() < 1 || wr_log[0] !== 32'h0004_0003) $display("FAIL ovf_first_written: required 00040003");
    else pass_n++;
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    total_n++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", overflow);
    else pass_n++;
    pulse_arm();
    send(1, 1'b0);
    clear_status = 1'b1;
    send(2, 1'b1);
    clear_status = 1'b0;
    total_n++;
    if (overflow !== 1'b1) $display("FAIL ovf_set_beats_clear: got %b, required 1", overflow);
    else pass_n++;
    for (int i = 0; i < 6; i++) send(0, 1'b0);
    step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  task automatic test_gapped();
    int bad;
    int d0;
    bad = 0;
    wr_log.delete();
    d0 = done_n;
    pulse_arm();
    for (int i = 0; i < 8; i++) begin
      send(i + 1, 1'b0);
      if (fifo_wr_en !== ((i % 2) == 1)) bad++;
      if (i < 7) begin
        step();
        if (fifo_wr_en !== 1'b0) bad++;
        step();
        if (fifo_wr_en !== 1'b0) bad++;
      end
    end
    step();
    total_n++;
    if (bad != 0) $display("FAIL gapped_strobe_timing: %0d bad cycles, required 0", bad);
    else pass_n++;
    total_n++;
    if (wr_log.size() !== 4 || done_n - d0 !== 1) $display("FAIL gapped_totals: writes=%0d dones=%0d, required 4/1", wr_log.size(), done_n - d0);
    else pass_n++;
    total_n++;
    if (wr_log.size() < 4 || wr_log[3] !== 32'h0008_0007) $display("FAIL gapped_last_word: required 00080007");
    else pass_n++;
  endtask

  task automatic test_reset_rearm();
    int d0;
    d0 = done_n;
    pulse_arm();
    send(7, 1'b0);
    send(8, 1'b1);
    send(9, 1'b0);
    rst_n = 1'b0;
    step();
    total_n++;
    if ({fifo_wr_en, fifo_din, busy, done, overflow, sample_count} !== '0) begin
      $display("FAIL midframe_reset: wr=%b din=%h busy=%b done=%b ovf=%b cnt=%0d, required all 0",
               fifo_wr_en, fifo_din, busy, done, overflow, sample_count);
    end else pass_n++;
    rst_n = 1'b1;
    step();
    step();
    total_n++;
    if (done_n != d0 || busy !== 1'b0) $display("FAIL midframe_no_done: dones=%0d busy=%b, required 0/0", done_n - d0, busy);
    else pass_n++;
    wr_log.delete();
    pulse_arm();
    for (int i = 1; i <= 8; i++) send(i * 10, 1'b0);
    step();
    total_n++;
    if (wr_log.size() !== 4 || wr_log[0] !== 32'h0014_000A || sample_count !== 4'd8) begin
      $display("FAIL rearm_clean_frame: writes=%0d cnt=%0d, required 4 writes, word0 0014000a, cnt 8", wr_log.size(), sample_count);
    end else pass_n++;
  endtask

`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
  task automatic test_trigger();
    int vals[12] = '{-5, -3, -1, 2, 4, 6, 8, 10, 12, 14, 16, 18};
    wr_log.delete();
    trig_level = '0;
    pulse_arm();
    total_n++;
    if (busy !== 1'b1) $display("FAIL trig_busy_armed: got %b, required 1", busy);
    else pass_n++;
    for (int i = 0; i < 11; i++) send(vals[i], 1'b0);
    step();
    total_n++;
    if (wr_log.size() !== 4 || wr_log[0] !== 32'h0004_0002 || sample_count !== 4'd8) begin
      $display("FAIL trig_first_word: writes=%0d cnt=%0d, required 4 writes, word0 00040002, cnt 8", wr_log.size(), sample_count);
    end else pass_n++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADC_FRAME_CAPTURE_TRIG_LEVEL_EN
    test_trigger();
`else
    test_basic_frame();
    test_sign_ext_arm_busy();
    test_overflow();
    test_gapped();
    test_reset_rearm();
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
